// File: rtl/ext_bus_ctrl.sv
// ext_bus_ctrl: serialises one CPU request onto a narrow pad bus, address beats (ALE) then data beats.
// Latency: 1+NA+WAIT_CYC+ND+stall cycles from the accept cycle to the one-cycle rsp_valid pulse.
// Backpressure: req_ready only in IDLE; pad_wait stalls data beats, aborted after TIMEOUT stall cycles (0 = never).
module ext_bus_ctrl #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int PIN_W    = 4,
    parameter int WAIT_CYC = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [PIN_W-1:0]  pad_out,
    input  logic [PIN_W-1:0]  pad_in,
    output logic [PIN_W-1:0]  pad_oe,
    output logic              pad_ale,
    output logic              pad_we,
    input  logic              pad_wait
);

    localparam int NA      = ADDR_W / PIN_W;
    localparam int ND      = DATA_W / PIN_W;
    localparam int MAX_A   = (NA > ND) ? NA : ND;
    localparam int MAX_B   = (MAX_A > WAIT_CYC) ? MAX_A : WAIT_CYC;
    localparam int CNT_MAX = (MAX_B > TIMEOUT) ? MAX_B : TIMEOUT;
    localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] NA_LAST   = CW'(NA - 1);
    localparam logic [CW-1:0] ND_LAST   = CW'(ND - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);
    localparam logic [CW-1:0] TO_LIM    = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_DATA,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     beat_cnt, beat_nxt;
    logic [CW-1:0]     stall_cnt, stall_nxt;
    logic [CW-1:0]     stall_inc;
    logic              err_q, err_nxt;
    logic              accept, addr_adv, data_adv;
    logic              we_q;
    logic [ADDR_W-1:0] addr_sh;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rdata_sh;
    logic [DATA_W-1:0] rd_next;

    assign stall_inc = stall_cnt + CW'(1);
    assign rd_next   = (rdata_sh << PIN_W) | DATA_W'(pad_in);

    // State, beat/stall counters and abort flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_nxt;
            stall_cnt <= stall_nxt;
            err_q     <= err_nxt;
        end
    end

    // Next-state, counter updates and pad/response outputs, all decoded from the current state.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        stall_nxt = stall_cnt;
        err_nxt   = err_q;
        accept    = 1'b0;
        addr_adv  = 1'b0;
        data_adv  = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        pad_out   = '0;
        pad_oe    = '0;
        pad_ale   = 1'b0;
        pad_we    = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = ~rst;
                if (req_valid && !rst) begin
                    accept    = 1'b1;
                    state_nxt = S_ADDR;
                    beat_nxt  = '0;
                    stall_nxt = '0;
                    err_nxt   = 1'b0;
                end
            end
            S_ADDR: begin
                pad_ale  = 1'b1;
                pad_oe   = '1;
                pad_we   = we_q;
                pad_out  = addr_sh[ADDR_W-1 -: PIN_W];
                addr_adv = 1'b1;
                if (beat_cnt == NA_LAST) begin
                    beat_nxt  = '0;
                    state_nxt = (WAIT_CYC > 0) ? S_WAIT : S_DATA;
                end else begin
                    beat_nxt = beat_cnt + CW'(1);
                end
            end
            S_WAIT: begin
                pad_we = we_q;
                pad_oe = we_q ? '1 : '0;
                if (beat_cnt == WAIT_LAST) begin
                    beat_nxt  = '0;
                    state_nxt = S_DATA;
                end else begin
                    beat_nxt = beat_cnt + CW'(1);
                end
            end
            S_DATA: begin
                pad_we = we_q;
                if (we_q) begin
                    pad_oe  = '1;
                    pad_out = wdata_sh[DATA_W-1 -: PIN_W];
                end
                if (pad_wait) begin
                    // Stall: beat and shift registers hold; only the stall counter moves.
                    if (TIMEOUT != 0) begin
                        stall_nxt = stall_inc;
                        if (stall_inc == TO_LIM) begin
                            err_nxt   = 1'b1;
                            stall_nxt = '0;
                            state_nxt = S_DONE;
                        end
                    end
                end else begin
                    data_adv  = 1'b1;
                    stall_nxt = '0;
                    if (beat_cnt == ND_LAST) begin
                        beat_nxt  = '0;
                        state_nxt = S_DONE;
                    end else begin
                        beat_nxt = beat_cnt + CW'(1);
                    end
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request capture, beat shift registers and the read-data result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            addr_sh   <= '0;
            wdata_sh  <= '0;
            rdata_sh  <= '0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                addr_sh  <= req_addr;
                wdata_sh <= req_wdata;
                rdata_sh <= '0;
            end
            if (addr_adv) begin
                addr_sh <= addr_sh << PIN_W;
            end
            if (data_adv) begin
                if (we_q) begin
                    wdata_sh <= wdata_sh << PIN_W;
                end else begin
                    rdata_sh <= rd_next;
                    // Final read beat: result is published together with rsp_valid.
                    if (beat_cnt == ND_LAST) begin
                        rsp_rdata <= rd_next;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// tb_ext_bus_ctrl: directed and random transfers on two controller instances (defaults; WAIT_CYC=3/TIMEOUT=8).
// Latency: expected response cycle, beats and read data come from a transfer-level model in the bench.
// Backpressure: pad_wait stall patterns are chosen per data-phase cycle, including timeout aborts.
module tb_ext_bus_ctrl;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int PW = 4;
    localparam int NA = 3;
    localparam int ND = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid0 = 1'b0;
    logic          req_valid1 = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [PW-1:0] pad_in = '0;
    logic          pad_wait = 1'b0;

    logic          rdy0, rdy1, rv0, rv1, re0, re1, ale0, ale1, pwe0, pwe1;
    logic [DW-1:0] rd0, rd1;
    logic [PW-1:0] po0, po1, oe0, oe1;

    logic          sel = 1'b0;
    logic          m_ready, m_rv, m_re, m_ale, m_pwe;
    logic [DW-1:0] m_rd;
    logic [PW-1:0] m_pout, m_oe;

    int            errors = 0;
    int            checks = 0;
    logic [3:0]    pin [64];
    logic [63:0]   wpat;
    logic [DW-1:0] last_rd [2];

    always #5 clk = ~clk;

    ext_bus_ctrl u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(rdy0), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv0), .rsp_err(re0),
        .rsp_rdata(rd0), .pad_out(po0), .pad_in(pad_in), .pad_oe(oe0), .pad_ale(ale0),
        .pad_we(pwe0), .pad_wait(pad_wait)
    );

    ext_bus_ctrl #(.WAIT_CYC(3), .TIMEOUT(8)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(rdy1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_err(re1),
        .rsp_rdata(rd1), .pad_out(po1), .pad_in(pad_in), .pad_oe(oe1), .pad_ale(ale1),
        .pad_we(pwe1), .pad_wait(pad_wait)
    );

    // Observe whichever instance the current step targets.
    always_comb begin
        m_ready = sel ? rdy1 : rdy0;
        m_rv    = sel ? rv1  : rv0;
        m_re    = sel ? re1  : re0;
        m_ale   = sel ? ale1 : ale0;
        m_pwe   = sel ? pwe1 : pwe0;
        m_rd    = sel ? rd1  : rd0;
        m_pout  = sel ? po1  : po0;
        m_oe    = sel ? oe1  : oe0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_pins();
        for (int i = 0; i < 64; i++) pin[i] = 4'($urandom);
    endtask

    // One transfer; expected timing, beats, err and read data come from walking the stall pattern.
    task automatic run_txn(input logic s, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int w, to, beats, stalls, j, jj, lat, n;
        int beat_at [64];
        logic err;
        logic [DW-1:0] rd;
        w = s ? 3 : 0;
        to = s ? 8 : 255;
        beats = 0; stalls = 0; j = 0; err = 1'b0; rd = '0;
        while (beats < ND && !err && j < 64) begin
            beat_at[j] = beats;
            if (wpat[j]) begin
                stalls++;
                if (to != 0 && stalls == to) err = 1'b1;
            end else begin
                rd = (rd << PW) | DW'(pin[j]);
                beats++;
                stalls = 0;
            end
            j++;
        end
        lat = 1 + NA + w + j;

        sel = s;
        @(negedge clk);
        n = 0;
        while (!m_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_req", m_ready, 1);
        req_we = we; req_addr = a; req_wdata = d;
        if (s) req_valid1 = 1'b1; else req_valid0 = 1'b1;
        pad_wait = 1'($urandom); pad_in = 4'($urandom);
        @(negedge clk);
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            if (c <= NA) begin
                pad_wait = 1'($urandom); pad_in = 4'($urandom);
                chk("addr_ale", m_ale, 1);
                chk("addr_oe", m_oe, 4'hF);
                chk("addr_we", m_pwe, we);
                chk("addr_beat", m_pout, (a >> (AW - c * PW)) & 4'hF);
            end else if (c <= NA + w) begin
                pad_wait = 1'($urandom); pad_in = 4'($urandom);
                chk("wait_ale", m_ale, 0);
                chk("wait_oe", m_oe, we ? 4'hF : 4'h0);
                chk("wait_out", m_pout, 0);
            end else if (c < lat) begin
                jj = c - NA - w - 1;
                pad_wait = wpat[jj]; pad_in = pin[jj];
                chk("data_ale", m_ale, 0);
                chk("data_we", m_pwe, we);
                chk("data_oe", m_oe, we ? 4'hF : 4'h0);
                chk("data_out", m_pout, we ? ((d >> (DW - (beat_at[jj] + 1) * PW)) & 4'hF) : 0);
            end else begin
                pad_wait = 1'($urandom); pad_in = 4'($urandom);
                chk("done_oe", m_oe, 0);
                chk("done_ale", m_ale, 0);
                chk("rsp_err", m_re, err);
            end
            chk("rsp_valid", m_rv, c == lat);
            @(negedge clk);
        end
        pad_wait = 1'b0;
        chk("rsp_after", m_rv, 0);
        if (!we && !err) last_rd[s] = rd;
        chk("rsp_rdata", m_rd, last_rd[s]);
        chk("ready_after", m_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc_n, rsp_n, ale_n, ovl, acc0, acc1, rsp0;
        last_rd[0] = '0; last_rd[1] = '0;

        // Reset state.
        #3;
        chk("rst_ready", m_ready, 0);
        chk("rst_ready1", rdy1, 0);
        chk("rst_rv", m_rv, 0);
        chk("rst_oe", m_oe, 0);
        chk("rst_ale", m_ale, 0);
        chk("rst_rdata", m_rd, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed write A5C/3E and read 123 returning 7,9.
        fill_pins(); wpat = '0;
        run_txn(1'b0, 1'b1, 12'hA5C, 8'h3E);
        fill_pins(); pin[0] = 4'h7; pin[1] = 4'h9; wpat = '0;
        run_txn(1'b0, 1'b0, 12'h123, 8'h00);
        chk("read_79", m_rd, 8'h79);

        // Two stall cycles in the first data beat; then a stall-free read with wait states.
        fill_pins(); wpat = 64'h3;
        run_txn(1'b0, 1'b0, 12'h456, 8'h00);
        fill_pins(); wpat = '0;
        run_txn(1'b1, 1'b0, 12'h789, 8'h00);

        // Stall counter clears per beat: 7 stalls twice, no abort.
        fill_pins(); wpat = 64'h7F7F;
        run_txn(1'b1, 1'b1, 12'hBCD, 8'hE1);
        // Stuck pad_wait: abort after 8 stall cycles, rdata held.
        fill_pins(); wpat = '1;
        run_txn(1'b1, 1'b0, 12'hFED, 8'h00);

        // Reset in the second address beat.
        sel = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_addr = 12'h5A5; req_wdata = 8'hC3; req_valid0 = 1'b1;
        @(negedge clk);
        req_valid0 = 1'b0;
        @(negedge clk);
        chk("pre_rst_ale", m_ale, 1);
        chk("pre_rst_beat", m_pout, 4'hA);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", m_ready, 0);
        chk("mid_rst_ale", m_ale, 0);
        chk("mid_rst_oe", m_oe, 0);
        chk("mid_rst_out", m_pout, 0);
        chk("mid_rst_we", m_pwe, 0);
        chk("mid_rst_rv", m_rv, 0);
        chk("mid_rst_rdata", m_rd, 0);
        @(negedge clk);
        rst = 1'b0;
        last_rd[0] = '0; last_rd[1] = '0;
        #1;
        chk("post_rst_ready", m_ready, 1);
        fill_pins(); wpat = '0;
        run_txn(1'b0, 1'b1, 12'h0F0, 8'h96);

        // Back-to-back writes with req_valid held.
        sel = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_addr = 12'h3C3; req_wdata = 8'h5A; pad_wait = 1'b0; req_valid0 = 1'b1;
        acc_n = 0; rsp_n = 0; ale_n = 0; ovl = 0; acc0 = -100; acc1 = -100; rsp0 = -100;
        for (int c = 0; c < 20; c++) begin
            if (m_ready && req_valid0) begin
                if (acc_n == 0) acc0 = c; else acc1 = c;
                acc_n++;
            end
            if (m_rv) begin
                if (rsp_n == 0) rsp0 = c;
                rsp_n++;
            end
            if (m_ale) ale_n++;
            if (m_ale && m_rv) ovl++;
            @(negedge clk);
            if (acc_n == 2) req_valid0 = 1'b0;
        end
        req_valid0 = 1'b0;
        chk("b2b_accepts", acc_n, 2);
        chk("b2b_rsps", rsp_n, 2);
        chk("b2b_first_lat", rsp0 - acc0, 6);
        chk("b2b_gap", acc1 - rsp0, 1);
        chk("b2b_ale_cycles", ale_n, 6);
        chk("b2b_overlap", ovl, 0);

        // Random transfers on both instances with sparse stalls.
        for (int i = 0; i < 24; i++) begin
            fill_pins();
            wpat = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if (i % 6 == 5) wpat = {$urandom, $urandom} | {$urandom, $urandom};
            run_txn(1'($urandom), 1'($urandom), 12'($urandom), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
